pulse_stretcher: RTL

//  Converts single-cycle strobes (e.g. edge-detector outputs, sync ticks) into a level held

---
 rtl/pulse_stretcher_pkg.sv | 22 ++
 rtl/pulse_stretcher_if.sv | 24 ++
 rtl/pulse_stretch_counter.sv | 38 +++
 rtl/pulse_stretcher.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher: FSM state encoding and
// the reload value used when the shared counter times the low gap.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Counter reload for a gap of gap_len cycles; a zero-length gap never loads.
    function automatic int gap_reload(input int gap_len);
        int val;
        if (gap_len > 32'sd0) begin
            val = gap_len - 32'sd1;
        end else begin
            val = 32'sd0;
        end
        return val;
    endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Strobe-in / level-out bundle of the pulse stretcher. The master side drives
// the clear, enable, trigger and length; the slave side (the stretcher)
// returns the stretched level, busy flag and done strobe.
interface pulse_stretcher_if #(
    parameter int CNT_W = 8
);
    logic             i_sclr;
    logic             i_en;
    logic             i_pulse;
    logic [CNT_W-1:0] i_len;
    logic             o_level;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_sclr, i_en, i_pulse, i_len,
        input  o_level, o_busy, o_done
    );

    modport slave (
        input  i_sclr, i_en, i_pulse, i_len,
        output o_level, o_busy, o_done
    );
endinterface

// File: rtl/pulse_stretch_counter.sv
// Loadable down-counter shared by the HOLD and GAP phases. It saturates at
// zero, so an idle counter simply sits at zero and reports o_zero.
module pulse_stretch_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_sclr,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_ld_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: load takes priority over decrement, never wraps below zero.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (i_sclr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (i_en) begin
            if (i_load) begin
                cnt_r <= i_ld_val;
            end else if (cnt_r != {CNT_W{1'b0}}) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign o_zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns a single-cycle trigger into a level held high for
// i_len clock cycles, optionally followed by a forced low gap of GAP_LEN
// cycles. Build option PULSE_STRETCHER_RETRIGGER_EN lets a new trigger during
// the high phase restart the stretch without a low glitch.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int GAP_LEN = 0
) (
    input  logic               clk,
    input  logic               i_rst_n,
    pulse_stretcher_if.slave   bus
);

    localparam bit               HAS_GAP = (GAP_LEN > 0);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(gap_reload(GAP_LEN));

    state_e           state_r;
    state_e           state_nxt_s;
    logic             trig_s;
    logic             retrig_s;
    logic [CNT_W-1:0] len_m1_s;
    logic             cnt_load_s;
    logic [CNT_W-1:0] cnt_ld_val_s;
    logic             cnt_zero_s;
    logic             leave_hold_s;
    logic             level_nxt_s;
    logic             busy_nxt_s;
    logic             done_nxt_s;
    logic             level_r;
    logic             busy_r;
    logic             done_r;

    // A zero-length trigger is treated as no trigger at all.
    assign trig_s   = bus.i_pulse && (bus.i_len != {CNT_W{1'b0}});
    assign len_m1_s = bus.i_len - CNT_W'(1);

`ifdef PULSE_STRETCHER_RETRIGGER_EN
    assign retrig_s = trig_s;
`else
    assign retrig_s = 1'b0;
`endif

    pulse_stretch_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .i_rst_n  (i_rst_n),
        .i_sclr   (bus.i_sclr),
        .i_en     (bus.i_en),
        .i_load   (cnt_load_s),
        .i_ld_val (cnt_ld_val_s),
        .o_zero   (cnt_zero_s)
    );

    // State register: clear wins over enable, disabled cycles freeze the FSM.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else if (bus.i_sclr) begin
            state_r <= ST_IDLE;
        end else if (bus.i_en) begin
            state_r <= state_nxt_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Next-state and counter control; retrigger in HOLD beats the exit check.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_load_s   = 1'b0;
        cnt_ld_val_s = {CNT_W{1'b0}};
        leave_hold_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (trig_s) begin
                    state_nxt_s  = ST_HOLD;
                    cnt_load_s   = 1'b1;
                    cnt_ld_val_s = len_m1_s;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (retrig_s) begin
                    state_nxt_s  = ST_HOLD;
                    cnt_load_s   = 1'b1;
                    cnt_ld_val_s = len_m1_s;
                end else if (cnt_zero_s) begin
                    leave_hold_s = 1'b1;
                    if (HAS_GAP) begin
                        state_nxt_s  = ST_GAP;
                        cnt_load_s   = 1'b1;
                        cnt_ld_val_s = GAP_LD;
                    end else begin
                        state_nxt_s  = ST_IDLE;
                    end
                end else begin
                    state_nxt_s  = ST_HOLD;
                end
            end
            ST_GAP: begin
                if (cnt_zero_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    always_comb begin
        level_nxt_s = (state_nxt_s == ST_HOLD);
        busy_nxt_s  = (state_nxt_s != ST_IDLE);
        done_nxt_s  = leave_hold_s;
    end

    // Output registers: same clear/enable gating as the state, so done is held when frozen.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            level_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (bus.i_sclr) begin
            level_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (bus.i_en) begin
            level_r <= level_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end else begin
            level_r <= level_r;
            busy_r  <= busy_r;
            done_r  <= done_r;
        end
    end

    assign bus.o_level = level_r;
    assign bus.o_busy  = busy_r;
    assign bus.o_done  = done_r;

endmodule
